// File: rtl/avsd_sar_adc_ctrl_pkg.sv
// avsd_sar_adc_ctrl shared types and defaults.
// State encoding and default conversion timing.
package avsd_adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    TRIAL
  } adc_state_e;

  localparam int ADC_WIDTH         = 10;
  localparam int ADC_SAMPLE_CYCLES = 4;
  localparam int ADC_SETTLE_CYCLES = 2;

endpackage

// File: rtl/avsd_sar_adc_ctrl_if.sv
// Core/analog side bundle of the SAR controller.
// slave is the controller, master the core plus comparator.
interface avsd_sar_adc_ctrl_if #(
  parameter int WIDTH = avsd_adc_pkg::ADC_WIDTH
);

  logic             START;
  logic             ABORT;
  logic             CMP;
  logic             SAMPLE;
  logic [WIDTH-1:0] D;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;

  modport slave (
    input  START,
    input  ABORT,
    input  CMP,
    output SAMPLE,
    output D,
    output BUSY,
    output DONE,
    output RESULT
  );

  modport master (
    output START,
    output ABORT,
    output CMP,
    input  SAMPLE,
    input  D,
    input  BUSY,
    input  DONE,
    input  RESULT
  );

endinterface

// File: rtl/avsd_adc_phase_cnt.sv
// Loadable down-counter timing sample and settle phases.
// tc flags the last cycle of the loaded phase.
module avsd_adc_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  // count down from the loaded value, parking at zero
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (load)
      cnt_q <= val;
    else if (en && cnt_q != '0)
      cnt_q <= cnt_q - W'(1);
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/avsd_sar_adc_ctrl.sv
// SAR ADC controller around the avsddac feedback DAC.
// Samples, then resolves one bit per settle phase, MSB first.
module avsd_sar_adc_ctrl
  import avsd_adc_pkg::*;
#(
  parameter int WIDTH         = ADC_WIDTH,
  parameter int SAMPLE_CYCLES = ADC_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = ADC_SETTLE_CYCLES
) (
  input logic                CLK,
  input logic                RESETN,
  avsd_sar_adc_ctrl_if.slave bus
);

  localparam int IW = $clog2(WIDTH);
  localparam int MX = (SAMPLE_CYCLES > SETTLE_CYCLES)
                    ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW = (MX > 1) ? $clog2(MX) : 1;
  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] SMP_LD =
    CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] STL_LD =
    CW'(SETTLE_CYCLES - 1);

  adc_state_e       state_q, state_n;
  logic [IW-1:0]    idx_q, idx_n;
  logic [WIDTH-1:0] code_q, code_n;
  logic [WIDTH-1:0] d_q, d_n;
  logic [WIDTH-1:0] res_q, res_n;
  logic             smp_q, smp_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             cnt_ld;
  logic [CW-1:0]    cnt_val;
  logic             cnt_en;
  logic             tc;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] decided;
  logic [IW-1:0]    idx_dec;

  avsd_adc_phase_cnt #(.W(CW)) u_cnt (
    .clk   (CLK),
    .rst_n (RESETN),
    .load  (cnt_ld),
    .val   (cnt_val),
    .en    (cnt_en),
    .tc    (tc)
  );

  assign mask    = ONE << idx_q;
  assign decided = code_q | (bus.CMP ? mask : '0);
  assign idx_dec = idx_q - IW'(1);

  // state and registered outputs
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      code_q  <= '0;
      d_q     <= '0;
      res_q   <= '0;
      smp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      code_q  <= code_n;
      d_q     <= d_n;
      res_q   <= res_n;
      smp_q   <= smp_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // next state, trial code and phase counter control
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    code_n  = code_q;
    d_n     = d_q;
    res_n   = res_q;
    smp_n   = 1'b0;
    busy_n  = busy_q;
    done_n  = 1'b0;
    cnt_ld  = 1'b0;
    cnt_val = STL_LD;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_n = 1'b0;
        if (!bus.ABORT && bus.START) begin
          state_n = SAMPLE;
          busy_n  = 1'b1;
          smp_n   = 1'b1;
          d_n     = '0;
          code_n  = '0;
          cnt_ld  = 1'b1;
          cnt_val = SMP_LD;
        end
      end
      SAMPLE: begin
        if (bus.ABORT) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          d_n     = '0;
          code_n  = '0;
        end else if (tc) begin
          state_n = TRIAL;
          idx_n   = IW'(WIDTH - 1);
          d_n     = code_q | (ONE << (WIDTH - 1));
          cnt_ld  = 1'b1;
        end else begin
          smp_n  = 1'b1;
          cnt_en = 1'b1;
        end
      end
      TRIAL: begin
        if (bus.ABORT) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          d_n     = '0;
          code_n  = '0;
        end else if (tc) begin
          code_n = decided;
          if (idx_q == '0) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            res_n   = decided;
            d_n     = decided;
          end else begin
            idx_n  = idx_dec;
            d_n    = decided | (ONE << idx_dec);
            cnt_ld = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.SAMPLE = smp_q;
  assign bus.D      = d_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.RESULT = res_q;

endmodule

// File: doc/avsd_sar_adc_ctrl.md
Name: avsd_sar_adc_ctrl

Overview:
Successive-approximation controller that turns the 10-bit avsddac into the feedback element of an ADC, completing the reverse (analog-to-digital) path.
- Drives the DAC code bus D and an external track/hold enable.
- Reads a single-bit analog comparator and builds the result MSB-first.
- Returns RESULT with a one-cycle DONE pulse to the SoC core.
- Sits between the core's register interface and the DAC/comparator macros.

Parameters:
- WIDTH, 10: conversion resolution; matches the DAC D width.
- SAMPLE_CYCLES, 4: cycles SAMPLE is held high before bit trials start; minimum 1.
- SETTLE_CYCLES, 2: cycles each trial code is held before CMP is sampled; minimum 1.

Ports:
- CLK, input, 1: single clock; all logic is on the rising edge.
- RESETN, input, 1: synchronous, active-low reset.
- START, input, 1: conversion request; sampled only when not BUSY.
- ABORT, input, 1: synchronous cancel of an in-progress conversion.
- CMP, input, 1: comparator output; 1 when Vin >= DAC OUT. Already synchronised externally.
- SAMPLE, output, 1: track/hold enable; high during the sample phase.
- D, output, WIDTH: trial code to avsddac D.
- BUSY, output, 1: conversion in progress.
- DONE, output, 1: one-cycle pulse when RESULT is updated.
- RESULT, output, WIDTH: last completed conversion.

Behaviour:
- Reset (RESETN=0 at an edge), from any state: state=IDLE, SAMPLE=0, D=0, BUSY=0, DONE=0, RESULT=0. Reset overrides START and ABORT.
- States: IDLE, SAMPLE, TRIAL.
- IDLE:
  - START=1 at an edge -> SAMPLE; BUSY=1, SAMPLE=1, D=0 from the next cycle.
  - START=0 -> stay; D holds the last RESULT, or 0 after reset/abort.
- SAMPLE: lasts exactly SAMPLE_CYCLES cycles, then -> TRIAL at bit WIDTH-1 with SAMPLE=0.
- TRIAL, bit i:
  - D = code | (1<<i), where code holds the bits already decided.
  - D is held for SETTLE_CYCLES cycles. At the edge ending the last of these cycles, CMP is sampled: CMP=1 keeps bit i, CMP=0 clears it.
  - Then move to bit i-1.
  - After bit 0: RESULT <= final code, D <= final code, DONE=1 for one cycle, BUSY=0 in the same cycle, state=IDLE.
- Latency: DONE is high in cycle SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES + 1 after the cycle in which START was sampled (25 with defaults). BUSY is high for exactly SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES cycles.
- Back-to-back: START=1 in the DONE cycle is accepted; the next conversion starts with no idle gap.
- START while BUSY: ignored, no queuing.
- ABORT=1 at an edge while BUSY: next cycle state=IDLE, BUSY=0, SAMPLE=0, D=0, no DONE, RESULT unchanged.
- ABORT while IDLE: no effect. ABORT and START together in IDLE: ABORT wins and START is dropped.
- Result encoding: unsigned. Code = floor((Vin-VREFL)/(VREFH-VREFL)*1023), saturating at 0 and 2^WIDTH-1 by construction.
- Outputs are registered; there is no combinational path from START, CMP or ABORT to any output.

Decomposition:
- Package avsd_adc_pkg holds:
  - the state enum (IDLE, SAMPLE, TRIAL);
  - default constants ADC_WIDTH=10, ADC_SAMPLE_CYCLES=4, ADC_SETTLE_CYCLES=2.
- One natural sub-module, avsd_adc_phase_cnt: a loadable down-counter with a terminal-count flag.
  - Loaded with SAMPLE_CYCLES-1 or SETTLE_CYCLES-1.
  - Its flag gates the bit-index decrement and the CMP sampling.
- The bit index is kept in the top level as a $clog2(WIDTH)-bit counter.

Test Plan:
- Directed reference level: bench comparator model CMP = (vin_code >= D), vin_code=0x2A5, START pulse -> DONE in cycle 25, RESULT=0x2A5, BUSY high exactly 24 cycles, D trial sequence starts 0x200, 0x300, 0x280.
- Endpoints: vin_code=0x000 -> RESULT=0x000; vin_code=0x3FF -> RESULT=0x3FF. Every trial bit is cleared or kept respectively.
- Back-to-back: vin_code 0x155 then 0x0AA, START held high continuously -> DONE pulses at cycles 25 and 50, RESULTs 0x155 then 0x0AA. Extra START pulses during BUSY change nothing.
- Abort: ABORT in cycle 10 of a conversion -> BUSY=0 and D=0 next cycle, no DONE, RESULT keeps its previous value. A new START then completes normally.
- Reset mid-conversion: RESETN=0 in cycle 12 -> next cycle all outputs 0 and state IDLE. A START issued in the same reset cycle is ignored.
- Parameter sweep: SAMPLE_CYCLES=1, SETTLE_CYCLES=1, WIDTH=10 -> DONE in cycle 12 with a correct RESULT for 16 random vin_codes.
